// File: rtl/phase_sequencer.sv
// Machine-cycle phase sequencer: one-hot phase enables with RAM wait states,
// halt at cycle boundary, single-step mode, cycle-start strobe and cycle counter.
module phase_sequencer #(
  parameter int unsigned NUM_PHASES = 3,
  parameter int unsigned WAIT_PHASE = 1,
  parameter int unsigned WAIT_W     = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  halt,
  input  logic                  step_mode,
  input  logic                  step,
  input  logic [WAIT_W-1:0]     ram_wait,
  output logic [NUM_PHASES-1:0] phase_out,
  output logic                  cycle_start,
  output logic                  running,
  output logic [CNT_W-1:0]      cycle_count
);

  localparam int unsigned IDX_W = $clog2(NUM_PHASES);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_PHASES - 1);
  localparam logic [IDX_W-1:0]      WAIT_IDX = IDX_W'(WAIT_PHASE);
  localparam logic [NUM_PHASES-1:0] PHASE0   = NUM_PHASES'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [WAIT_W-1:0] wait_cnt;

  logic              go;
  logic              last_phase;
  logic              wait_done;
  logic [IDX_W-1:0]  next_idx;
  logic [WAIT_W-1:0] phase0_wait;

  // Decode helpers; phase0_wait covers the case where phase 0 is the stretched one
  always_comb begin
    go          = !halt && (!step_mode || step);
    last_phase  = (idx == LAST_IDX);
    wait_done   = (wait_cnt == '0);
    next_idx    = idx + IDX_W'(1);
    phase0_wait = (WAIT_PHASE == 0) ? ram_wait : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      phase_out   <= '0;
      cycle_start <= 1'b0;
      running     <= 1'b0;
      cycle_count <= '0;
    end else begin
      cycle_start <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state       <= ACTIVE;
            idx         <= '0;
            phase_out   <= PHASE0;
            cycle_start <= 1'b1;
            running     <= 1'b1;
            wait_cnt    <= phase0_wait;
          end
        end
        ACTIVE: begin
          if (!wait_done) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else if (!last_phase) begin
            idx       <= next_idx;
            phase_out <= phase_out << 1;
            if (next_idx == WAIT_IDX) begin
              wait_cnt <= ram_wait;
            end
          end else begin
            // End of the last phase: the cycle is complete and control inputs are honoured
            cycle_count <= cycle_count + CNT_W'(1);
            idx         <= '0;
            if (halt || step_mode) begin
              state     <= IDLE;
              phase_out <= '0;
              running   <= 1'b0;
              wait_cnt  <= '0;
            end else begin
              phase_out   <= PHASE0;
              cycle_start <= 1'b1;
              wait_cnt    <= phase0_wait;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench: two phase_sequencer configurations driven with directed and
// random control, compared every clock against a remaining-clocks reference model.
module tb_phase_sequencer;

  logic       clk;
  logic       reset_n;
  logic       halt;
  logic       step_mode;
  logic       step;
  logic [1:0] ram_wait;

  logic [2:0] a_phase;
  logic       a_start;
  logic       a_run;
  logic [3:0] a_count;

  logic [4:0]  b_phase;
  logic        b_start;
  logic        b_run;
  logic [15:0] b_count;

  int n_cmp;
  int n_err;

  phase_sequencer #(.NUM_PHASES(3), .WAIT_PHASE(1), .WAIT_W(2), .CNT_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .halt(halt), .step_mode(step_mode), .step(step),
    .ram_wait(ram_wait), .phase_out(a_phase), .cycle_start(a_start),
    .running(a_run), .cycle_count(a_count)
  );

  phase_sequencer #(.NUM_PHASES(5), .WAIT_PHASE(4), .WAIT_W(2), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .halt(halt), .step_mode(step_mode), .step(step),
    .ram_wait(ram_wait), .phase_out(b_phase), .cycle_start(b_start),
    .running(b_run), .cycle_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which phase is lit and how many clocks it still has to run
  typedef struct {
    bit act;
    int p;
    int rem;
    int cnt;
    bit st;
  } mstate_t;

  mstate_t ma;
  mstate_t mb;

  function automatic mstate_t mreset();
    mstate_t s;
    s.act = 1'b0; s.p = 0; s.rem = 0; s.cnt = 0; s.st = 1'b0;
    return s;
  endfunction

  function automatic int phase_len(int p, int wp, int rw);
    return (p == wp) ? 1 + rw : 1;
  endfunction

  function automatic mstate_t mstep(mstate_t s, int n, int wp, int cw,
                                    bit h, bit sm, bit stp, int rw);
    mstate_t r;
    r = s;
    r.st = 1'b0;
    if (!s.act) begin
      if (!h && (!sm || stp)) begin
        r.act = 1'b1; r.p = 0; r.rem = phase_len(0, wp, rw); r.st = 1'b1;
      end
    end else begin
      r.rem = s.rem - 1;
      if (r.rem == 0) begin
        if (s.p < n - 1) begin
          r.p = s.p + 1;
          r.rem = phase_len(r.p, wp, rw);
        end else begin
          r.cnt = (s.cnt + 1) % (1 << cw);
          if (h || sm) begin
            r.act = 1'b0; r.p = 0; r.rem = 0;
          end else begin
            r.p = 0; r.rem = phase_len(0, wp, rw); r.st = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] ea;
    logic [31:0] eb;
    ea = ma.act ? (32'd1 << ma.p) : 32'd0;
    eb = mb.act ? (32'd1 << mb.p) : 32'd0;
    check("a_phase", 32'(a_phase), ea);
    check("a_start", 32'(a_start), 32'(ma.st));
    check("a_running", 32'(a_run), 32'(ma.act));
    check("a_count", 32'(a_count), 32'(ma.cnt));
    check("a_onehot", 32'(a_run ? $onehot(a_phase) : (a_phase == 3'd0)), 32'd1);
    check("b_phase", 32'(b_phase), eb);
    check("b_start", 32'(b_start), 32'(mb.st));
    check("b_running", 32'(b_run), 32'(mb.act));
    check("b_count", 32'(b_count), 32'(mb.cnt));
    check("b_onehot", 32'(b_run ? $onehot(b_phase) : (b_phase == 5'd0)), 32'd1);
  endtask

  // One clock: model advances on the inputs the DUT sampled, outputs checked 1ns later
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!reset_n) begin
        ma = mreset();
        mb = mreset();
      end else begin
        ma = mstep(ma, 3, 1, 4, halt, step_mode, step, int'(ram_wait));
        mb = mstep(mb, 5, 4, 16, halt, step_mode, step, int'(ram_wait));
      end
      #1;
      check_all();
    end
  endtask

  // Asynchronous reset pulse away from the clock edge, checked while asserted
  task automatic reset_pulse();
    #1 reset_n = 1'b0;
    #1;
    ma = mreset();
    mb = mreset();
    check_all();
    #1 reset_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ma = mreset();
    mb = mreset();
    reset_n = 1'b0; halt = 1'b0; step_mode = 1'b0; step = 1'b0; ram_wait = 2'd0;
    tick(2);
    #2 reset_n = 1'b1;

    // Free run, no waits
    tick(13);
    check("a_count_after_12", 32'(a_count), 32'd4);

    // Stretched wait phase, ram_wait dropped while held
    ram_wait = 2'd2;
    tick(2);
    ram_wait = 2'd0;
    tick(12);
    ram_wait = 2'd3;
    tick(10);
    ram_wait = 2'd1;
    tick(12);
    ram_wait = 2'd0;

    // Halt mid-cycle completes the cycle, then resume
    tick(1);
    halt = 1'b1;
    tick(10);
    halt = 1'b0;
    tick(7);

    // Single step mode
    step_mode = 1'b1;
    tick(6);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(8);
    step = 1'b1; halt = 1'b1;
    tick(4);
    halt = 1'b0;
    tick(14);
    step = 1'b0;
    tick(6);
    step_mode = 1'b0;

    // Long run for counter wrap, then reset mid-cycle
    tick(60);
    tick(1);
    reset_pulse();
    tick(9);

    // Randomized control
    for (int i = 0; i < 2500; i++) begin
      halt = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) step_mode = ~step_mode;
      step = ($urandom_range(0, 3) == 0);
      ram_wait = 2'($urandom);
      if ($urandom_range(0, 399) == 0) reset_pulse();
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
